// File: rtl/dcc_pkg.sv
// Shared types and helpers for the duty-cycle monitor: timestamp type,
// monitor state encoding and the expected-high-time arithmetic.
`timescale 1ns/1ps
package dcc_pkg;

    localparam int unsigned DCC_SCALE = 1000;

    typedef logic [63:0] ts_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ARMED   = ST_ARMED,
        MEASURE = ST_MEASURE
    } dcc_state_e;

    // Real time (in the caller's ns time unit) to integer ps, rounded.
    function automatic ts_t to_ps(input realtime t_ns);
        return ts_t'(t_ns * 1000.0);
    endfunction

    function automatic ts_t exp_high_ps(input logic [31:0] period_ps,
                                        input logic [31:0] duty_1000,
                                        input int unsigned scale);
        return (ts_t'(period_ps) * ts_t'(duty_1000)) / ts_t'(scale);
    endfunction

    function automatic ts_t abs_diff(input ts_t a, input ts_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/dcc_edge_timer.sv
// Timestamps rise/fall edges of clk while armed and reports each complete
// high phase as high_ps with a strobe held from the negedge to the next posedge.
`timescale 1ns/1ps
module dcc_edge_timer
    import dcc_pkg::*;
(
    input  logic clk,
    input  logic arm,
    output ts_t  high_ps,
    output logic sample_valid
);

    dcc_state_e state_q;
    ts_t        t_rise_q;
    ts_t        t_arm_q;
    ts_t        high_q;
    logic       valid_q;

    // Time at which monitoring was (re)enabled; a rise stamped at this same
    // instant coincided with reset release or LOCKED rising and is not used.
    always_ff @(posedge arm) begin
        t_arm_q <= to_ps($realtime);
    end

    // Both clock edges share one process; clk level tells which edge fired.
    always_ff @(posedge clk or negedge clk or negedge arm) begin
        if (!arm) begin
            state_q  <= IDLE;
            t_rise_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
        end else if (clk) begin
            state_q  <= MEASURE;
            t_rise_q <= to_ps($realtime);
            valid_q  <= 1'b0;
        end else begin
            state_q <= ARMED;
            if (state_q == MEASURE) begin
                high_q  <= to_ps($realtime) - t_rise_q;
                valid_q <= (t_rise_q != t_arm_q);
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign high_ps      = high_q;
    assign sample_valid = valid_q;

endmodule

// File: rtl/duty_cycle_check.sv
// Simulation monitor: flags (sticky) any high phase of clk whose width differs
// from period*duty/1000 by more than TOLERANCE_PS while LOCKED is high.
`timescale 1ns/1ps
module duty_cycle_check
    import dcc_pkg::*;
#(
    parameter int unsigned TOLERANCE_PS = 1,
    parameter int unsigned SCALE        = DCC_SCALE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] desired_duty_cycle_1000,
    input  logic [31:0] clk_period_1000,
    input  logic        LOCKED,
    output logic        fail
);

    logic arm;
    ts_t  high_ps;
    logic sample_valid;
    logic cfg_ok;
    ts_t  exp_ps;
    logic fail_q;

    assign arm = reset & LOCKED;

    dcc_edge_timer u_timer (
        .clk          (clk),
        .arm          (arm),
        .high_ps      (high_ps),
        .sample_valid (sample_valid)
    );

    always_comb begin
        cfg_ok = (desired_duty_cycle_1000 != '0) &&
                 (desired_duty_cycle_1000 < 32'(SCALE)) &&
                 (clk_period_1000 != '0);
        exp_ps = exp_high_ps(clk_period_1000, desired_duty_cycle_1000, SCALE);
        if (!cfg_ok)
            $warning("duty_cycle_check: duty %0d / period %0d ps out of range, checking suspended",
                     desired_duty_cycle_1000, clk_period_1000);
    end

    // Evaluated on the strobe edge so fail rises in the negedge's time step.
    always_ff @(posedge sample_valid or negedge reset) begin
        if (!reset)
            fail_q <= 1'b0;
        else if (cfg_ok && (abs_diff(high_ps, exp_ps) > ts_t'(TOLERANCE_PS)))
            fail_q <= 1'b1;
    end

    assign fail = fail_q;

endmodule

// File: tb/tb_duty_cycle_check.sv
// Directed bench for duty_cycle_check: hand-shaped clock phases with
// hand-computed expectations for the sticky fail flag.
`timescale 1ns/1ps
module tb_duty_cycle_check;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] duty  = 32'd500;
    logic [31:0] period = 32'd10000;
    logic        locked = 1'b0;
    logic        fail;

    int unsigned checks = 0;
    int unsigned errors = 0;

    duty_cycle_check #(.TOLERANCE_PS(1)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .desired_duty_cycle_1000 (duty),
        .clk_period_1000         (period),
        .LOCKED                  (locked),
        .fail                    (fail)
    );

    task automatic cyc(input realtime hi, input realtime lo);
        clk = 1'b1;
        #(hi);
        clk = 1'b0;
        #(lo);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held low: even a locked, wrong-duty clock cannot set fail.
        #1;
        chk("reset_initial", fail, 1'b0);
        locked = 1'b1;
        cyc(4, 6);
        cyc(4, 6);
        chk("reset_held_bad_clock", fail, 1'b0);

        // Not locked: 40 % clock ignored.
        reset  = 1'b1;
        locked = 1'b0;
        repeat (3) cyc(4, 6);
        chk("not_locked", fail, 1'b0);

        // Locked, matching 50 % clock.
        locked = 1'b1;
        repeat (100) cyc(5, 5);
        chk("match_50pct", fail, 1'b0);

        // 40 % clock: first full high phase of 4000 ps must flag.
        cyc(4, 6);
        chk("mismatch_first_phase", fail, 1'b1);
        repeat (99) cyc(4, 6);
        chk("mismatch_stays", fail, 1'b1);

        // Sticky across LOCKED falling; cleared only by reset.
        locked = 1'b0;
        cyc(5, 5);
        chk("sticky_unlocked", fail, 1'b1);
        reset = 1'b0;
        #1;
        chk("reset_clears", fail, 1'b0);
        reset  = 1'b1;
        locked = 1'b1;
        #1;
        repeat (10) cyc(5, 5);
        chk("match_after_reset", fail, 1'b0);

        // Tolerance of 1 ps.
        repeat (5) cyc(5.001, 4.999);
        chk("tol_plus1", fail, 1'b0);
        cyc(4.999, 5.001);
        chk("tol_minus1", fail, 1'b0);
        cyc(5.002, 4.998);
        chk("tol_plus2", fail, 1'b1);

        // Reset mid high phase clears fail at once; that phase is discarded.
        clk = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("reset_mid_phase", fail, 1'b0);
        reset = 1'b1;
        #1;
        clk = 1'b0;
        #5;
        chk("partial_after_reset", fail, 1'b0);
        cyc(5, 5);
        chk("match_after_mid_reset", fail, 1'b0);

        // LOCKED rising inside a high phase: that phase is not checked.
        locked = 1'b0;
        clk = 1'b1;
        #1;
        locked = 1'b1;
        #1;
        clk = 1'b0;
        #5;
        chk("lock_mid_high", fail, 1'b0);

        // LOCKED dropping inside a high phase discards the captured rise.
        clk = 1'b1;
        #1;
        locked = 1'b0;
        #1;
        locked = 1'b1;
        #1;
        clk = 1'b0;
        #5;
        chk("unlock_discard", fail, 1'b0);
        cyc(5, 5);
        chk("match_after_relock", fail, 1'b0);

        // New duty takes effect on the next completed phase: 400 -> 4000 ps.
        duty = 32'd400;
        repeat (3) cyc(4, 6);
        chk("duty400_match", fail, 1'b0);
        cyc(5, 5);
        chk("duty400_mismatch", fail, 1'b1);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;

        // Out-of-range configuration suspends checking.
        duty = 32'd0;
        cyc(2, 8);
        chk("duty_zero", fail, 1'b0);
        duty = 32'd1000;
        cyc(2, 8);
        chk("duty_1000", fail, 1'b0);
        duty   = 32'd500;
        period = 32'd0;
        cyc(2, 8);
        chk("period_zero", fail, 1'b0);
        period = 32'd10000;
        cyc(5, 5);
        chk("valid_again_match", fail, 1'b0);
        cyc(3, 7);
        chk("valid_again_mismatch", fail, 1'b1);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;

        // Other ratio: 20000 * 250 / 1000 = 5000 ps.
        period = 32'd20000;
        duty   = 32'd250;
        repeat (3) cyc(5, 15);
        chk("p20000_d250", fail, 1'b0);

        // Truncation: 10002 * 333 / 1000 = 3330 (3330.666 truncated).
        period = 32'd10002;
        duty   = 32'd333;
        cyc(3.331, 6.671);
        chk("trunc_diff1", fail, 1'b0);
        cyc(3.332, 6.670);
        chk("trunc_diff2", fail, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/duty_cycle_check.md
Name: duty_cycle_check

Overview:
- Verification-side monitor. It watches one clock and checks that its measured high time matches a programmed duty cycle of a programmed period.
- Used inside PLL/clock-generator testbenches to flag duty-cycle errors on generated outputs once the source reports lock.
- Behavioural (simulation-only) block. It measures edge-to-edge time with the simulator's real time; it is not meant for synthesis.

Parameters:
- TOLERANCE_PS, 1: maximum allowed absolute difference, in ps, between measured and expected high time. Absorbs rounding.
- SCALE, 1000: fixed-point scale of both inputs. Must not be overridden.

Ports:
- clk, input, 1: clock under test. Also the only event source.
- reset, input, 1: asynchronous, active-low reset. Low forces every internal state and `fail` to 0 immediately.
- desired_duty_cycle_1000, input, 32: required duty cycle ×1000, unsigned. 500 = 50 %. Valid range 1..999.
- clk_period_1000, input, 32: nominal clk period ×1000 in ns, i.e. ps, unsigned. 10000 = 10 ns.
- LOCKED, input, 1: checking is enabled only while high.
- fail, output, 1: sticky error flag.

Behaviour:
- Time base: timescale 1 ns / 1 ps. Edge timestamps are taken as $realtime×1000, rounded to integer ps, held in 64-bit.
- Expected high time: exp_high_ps = clk_period_1000 × desired_duty_cycle_1000 / 1000.
  - Compute in 64-bit unsigned, then integer-divide (truncate).
  - Inputs are sampled at each negedge, so a change takes effect on the next completed high phase.
- States:
  - IDLE: reset low, or LOCKED low.
  - ARMED: LOCKED high, waiting for a posedge.
  - MEASURE: posedge timestamp captured, waiting for a negedge.
- Transitions:
  - IDLE → ARMED when reset is high and LOCKED is high.
  - ARMED → MEASURE on a posedge. Record t_rise.
  - MEASURE → ARMED on a negedge:
    - compute high_ps = t_neg − t_rise;
    - if |high_ps − exp_high_ps| > TOLERANCE_PS, set fail = 1.
- Partial first phase: a negedge seen in ARMED without a prior captured posedge is ignored. A phase already in progress when LOCKED rises is never checked.
- LOCKED falling:
  - any state → IDLE; a pending measurement is discarded;
  - fail keeps its current value (sticky).
- fail:
  - 0 after reset;
  - set only by a mismatch;
  - cleared only by reset going low;
  - never asserted while LOCKED has been low since reset.
- Reset mid-measurement: the pending t_rise is discarded, fail = 0 immediately, state = IDLE.
- Simultaneous reset release and clk edge: reset is evaluated first, so that edge is not used for measurement.
- Zero or out-of-range inputs:
  - desired_duty_cycle_1000 = 0 or ≥ 1000, or clk_period_1000 = 0: no check is performed and fail is not set;
  - a $warning is issued once per change.
- Latency: fail rises in the same time step as the negedge that ends the offending high phase.

Decomposition:
- Shared package dcc_pkg:
  - DCC_SCALE = 1000;
  - time-stamp type (64-bit unsigned ps);
  - state enum {IDLE, ARMED, MEASURE}.
- One natural sub-module: dcc_edge_timer.
  - Captures rise/fall timestamps.
  - Outputs high_ps plus a one-step "sample valid" strobe.
  - The top block handles expected-value arithmetic, comparison, enable/sticky logic.

Test Plan:
- Reset: hold reset low for 10 ns with clk toggling → fail = 0 throughout.
- Not locked: reset high, LOCKED = 0, 10 ns clk at 40 % (inputs 500/10000) for 30 ns → fail stays 0.
- Match: LOCKED = 1, clk 10 ns period 50 % high, inputs 500/10000, run 1000 ns → fail = 0 (high_ps = 5000 = exp).
- Mismatch: same inputs, stimulus changed to 40 % (4 ns high), run 1000 ns → fail = 1 after the first full 4000 ps high phase, and remains 1.
- Tolerance edge: TOLERANCE_PS = 1, high phase 5001 ps → fail = 0; high phase 5002 ps → fail = 1.
- Sticky/reset: after fail = 1, drop LOCKED → fail stays 1; pulse reset low → fail = 0, then a matching clock keeps it 0.
